alu_instr_encoder: RTL
======================

ALU_INSTR_ENCODER -- requirements
Module: alu_instr_encoder

Interface
REQ-001 Parameters SHALL be: DEPTH, default 64, number of instruction words the block may write (2..1024); BASE_ADDR, default 32'h0, byte address of the first word written.
REQ-002 Ports SHALL be (name direction width meaning): clk in 1 single clock, all logic on rising edge; rst in 1 reset, synchronous, active-high.
REQ-003 req_valid in 1 request present; req_ready out 1 block can accept a request.
REQ-004 req_alu_ctrl in 3 ALU operation code: 000 add, 001 sub, 010 and, 011 or, 101 slt; all other codes illegal.
REQ-005 req_imm_form in 1 1 = I-type (OP-IMM), 0 = R-type (OP); req_rd, req_rs1, req_rs2 in 5 each register indices; req_imm in 12 I-type immediate.
REQ-006 mem_we out 1 write request; mem_addr out 32 byte address; mem_wdata out 32 encoded instruction word; mem_ack in 1 write accepted.
REQ-007 err_illegal out 1 one-cycle pulse, request rejected; full out 1 DEPTH words written; count out clog2(DEPTH+1) words written; clear in 1 restart the write pointer.

Function
REQ-008 The block SHALL encode each accepted request into an RV32I word and write it to mem_addr = BASE_ADDR + 4*count.
REQ-009 R-type: opcode 0110011, [11:7]=rd, [19:15]=rs1, [24:20]=rs2; funct7 = 0100000 for sub, else 0000000.
REQ-010 I-type: opcode 0010011, [11:7]=rd, [19:15]=rs1, [31:20]=req_imm.
REQ-011 funct3: add/sub 000, slt 010, or 110, and 111.
REQ-012 Illegal: reserved req_alu_ctrl codes (100, 110, 111), and sub with req_imm_form=1.
REQ-013 FSM states SHALL be IDLE, ENCODE, WRITE, FULL.
REQ-014 IDLE: req_ready=1; on req_valid&req_ready all req_* fields are registered, go to ENCODE.
REQ-015 ENCODE (1 cycle): legal -> register word, address, go to WRITE; illegal -> err_illegal=1 for the following cycle only, no write, count unchanged, return to IDLE.
REQ-016 WRITE: mem_we=1, mem_addr/mem_wdata held stable until mem_ack sampled high; mem_ack in the first WRITE cycle completes the write.
REQ-017 On ack: mem_we deasserts next cycle, count increments; count==DEPTH -> FULL, else IDLE.
REQ-018 Minimum latency: request accepted at edge N -> mem_we high from cycle N+2; throughput at most one word per 3 cycles.
REQ-019 req_ready SHALL be 0 in ENCODE, WRITE and FULL; mem_ack while mem_we=0 SHALL be ignored.
REQ-020 FULL: full=1, req_ready=0; exit only via clear or rst.
REQ-021 clear in IDLE or FULL: count=0, full=0, next state IDLE; clear in ENCODE or WRITE ignored (in-flight write completes).
REQ-022 rd=0 and any register indices SHALL be encoded without special-casing.

Reset
REQ-023 On rst high at a clock edge: state IDLE, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, full=0, err_illegal=0, req_ready=1 next cycle.
REQ-024 rst mid-WRITE SHALL abandon the write (mem_we=0 next cycle, count not incremented); rst SHALL override clear and req_valid.

Verification
REQ-025 R add rd=3 rs1=1 rs2=2, mem_ack immediate -> mem_we one cycle, mem_addr 0x0, mem_wdata 0x002081B3, count 1.
REQ-026 R sub rd=5 rs1=6 rs2=7 -> mem_addr 0x4, mem_wdata 0x40730283 | 0x30 = 0x407302B3, count 2.
REQ-027 I and rd=1 rs1=2 imm=0x0FF -> mem_wdata 0x0FF17093; I or rd=1 rs1=1 imm=0 -> 0x0000E093.
REQ-028 req_alu_ctrl=100, then sub with req_imm_form=1 -> each gives one err_illegal pulse, mem_we stays 0, count unchanged.
REQ-029 mem_ack held low 3 cycles in WRITE -> mem_we, mem_addr, mem_wdata stable, req_ready 0 for all 3; completes on 4th cycle.
REQ-030 DEPTH=2: two legal writes -> full=1, req_ready=0, further req_valid ignored; clear -> count 0, next write at BASE_ADDR; rst asserted during WRITE -> mem_we 0 next cycle, count 0.

Source files
------------

// File: rtl/alu_instr_encoder_if.sv
// Request / memory-write bus of the ALU instruction encoder.
// The master side issues requests and acknowledges writes; the slave side is the encoder.
interface alu_instr_encoder_if #(
    parameter int unsigned DEPTH = 64
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_alu_ctrl;
    logic          req_imm_form;
    logic [4:0]    req_rd;
    logic [4:0]    req_rs1;
    logic [4:0]    req_rs2;
    logic [11:0]   req_imm;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ack;
    logic          err_illegal;
    logic          full;
    logic [CW-1:0] count;
    logic          clear;

    modport master (
        output req_valid, req_alu_ctrl, req_imm_form, req_rd, req_rs1, req_rs2, req_imm,
        output mem_ack, clear,
        input  req_ready, mem_we, mem_addr, mem_wdata, err_illegal, full, count
    );

    modport slave (
        input  req_valid, req_alu_ctrl, req_imm_form, req_rd, req_rs1, req_rs2, req_imm,
        input  mem_ack, clear,
        output req_ready, mem_we, mem_addr, mem_wdata, err_illegal, full, count
    );
endinterface

// File: rtl/alu_instr_encoder.sv
// Encodes ALU requests into RV32I OP / OP-IMM words and writes them to consecutive
// word addresses starting at BASE_ADDR, until DEPTH words have been written.
module alu_instr_encoder #(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input logic               clk,
    input logic               rst,
    alu_instr_encoder_if.slave bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StEncode, StWrite, StFull} state_t;

    state_t        state_q, state_d;
    logic [2:0]    ctrl_q;
    logic          form_q;
    logic [4:0]    rd_q, rs1_q, rs2_q;
    logic [11:0]   imm_q;
    logic [CW-1:0] count_q, count_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          err_q, err_d;
    logic          accept;

    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic          illegal;
    logic [31:0]   word;

    // Decode the captured request into funct fields, legality and the encoded word.
    always_comb begin
        funct3  = 3'b000;
        funct7  = 7'b0000000;
        illegal = 1'b0;
        case (ctrl_q)
            3'b000:  funct3 = 3'b000;
            3'b001: begin
                funct3 = 3'b000;
                funct7 = 7'b0100000;
            end
            3'b010:  funct3 = 3'b111;
            3'b011:  funct3 = 3'b110;
            3'b101:  funct3 = 3'b010;
            default: illegal = 1'b1;
        endcase
        // There is no subtract-immediate in RV32I.
        if (ctrl_q == 3'b001 && form_q) begin
            illegal = 1'b1;
        end
        if (form_q) begin
            word = {imm_q, rs1_q, funct3, rd_q, 7'b0010011};
        end else begin
            word = {funct7, rs2_q, rs1_q, funct3, rd_q, 7'b0110011};
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.clear) begin
                    count_d = '0;
                end
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    state_d = StEncode;
                end
            end
            StEncode: begin
                if (illegal) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    we_d    = 1'b1;
                    addr_d  = BASE_ADDR + (32'(count_q) << 2);
                    wdata_d = word;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                // clear is deliberately ignored here so the in-flight write completes.
                if (bus.mem_ack) begin
                    we_d    = 1'b0;
                    count_d = count_q + CW'(1);
                    state_d = (32'(count_q) + 32'd1 == DEPTH) ? StFull : StIdle;
                end
            end
            StFull: begin
                if (bus.clear) begin
                    count_d = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset overrides clear and any request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            ctrl_q  <= 3'b000;
            form_q  <= 1'b0;
            rd_q    <= 5'd0;
            rs1_q   <= 5'd0;
            rs2_q   <= 5'd0;
            imm_q   <= 12'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            if (accept) begin
                ctrl_q <= bus.req_alu_ctrl;
                form_q <= bus.req_imm_form;
                rd_q   <= bus.req_rd;
                rs1_q  <= bus.req_rs1;
                rs2_q  <= bus.req_rs2;
                imm_q  <= bus.req_imm;
            end
        end
    end

    assign bus.req_ready   = (state_q == StIdle);
    assign bus.full        = (state_q == StFull);
    assign bus.count       = count_q;
    assign bus.mem_we      = we_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.err_illegal = err_q;
endmodule
